// File: rtl/time_set_entry.sv
// time_set_entry: button-driven editor producing the 12-hour BCD preset word for the clock core.
// Latency: a button first sampled high at edge k acts at edge k+2 (k+2+DEBOUNCE_CYCLES when
// `TIME_SET_DEBOUNCE_EN is defined); all outputs registered. No backpressure: loadStrobe is a one-cycle pulse.
module time_set_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        btnMode,
  input  logic        btnUp,
  input  logic        btnDown,
  input  logic [23:0] clockBitsCurrent,
  output logic [23:0] clockBitsIn,
  output logic        loadStrobe,
  output logic        editing,
  output logic [1:0]  fieldSel
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EDIT_HH = 3'd1,
    EDIT_MM = 3'd2,
    EDIT_SS = 3'd3,
    COMMIT  = 3'd4
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  // A zero count would make the timeout and debounce counters meaningless.
  if (TIMEOUT_CYCLES < 1 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("time_set_entry: TIMEOUT_CYCLES and DEBOUNCE_CYCLES must be at least 1");
  end

  // ---------------------------------------------------------------- buttons
  // Bit order everywhere in the front end: [2] = mode, [1] = up, [0] = down.
  logic [2:0] btn_raw;
  logic [2:0] sync1_q, sync2_q;
  logic [2:0] level;
  logic [2:0] edge_q;
  logic [2:0] pulse;
  logic       p_mode, p_up, p_down;

  assign btn_raw = {btnMode, btnUp, btnDown};

  // Two-flop synchronizer for the asynchronous push-buttons.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

`ifdef TIME_SET_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] db_cnt_q [3];
  logic [2:0]    db_lvl_q;

  // Accept a new level only after it has differed from the accepted one for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts the count.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      db_lvl_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2_q[i] == db_lvl_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          db_lvl_q[i] <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign level = db_lvl_q;
`else
  assign level = sync2_q;
`endif

  // Rising-edge detector: one pulse per press no matter how long it is held.
  always_ff @(posedge clk) begin
    if (!resetN) edge_q <= '0;
    else         edge_q <= level;
  end

  assign pulse  = level & ~edge_q;
  assign p_mode = pulse[2];
  assign p_up   = pulse[1];
  assign p_down = pulse[0];

  // ------------------------------------------------------------ BCD helpers
  function automatic logic hh_ok(input logic [7:0] v);
    return (v[7:4] == 4'd0 && v[3:0] != 4'd0 && v[3:0] <= 4'd9) ||
           (v[7:4] == 4'd1 && v[3:0] <= 4'd2);
  endfunction

  function automatic logic ms_ok(input logic [7:0] v);
    return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
  endfunction

  function automatic logic [7:0] hh_inc(input logic [7:0] v);
    if (v == 8'h12)      return 8'h01;
    if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] hh_dec(input logic [7:0] v);
    if (v == 8'h01)      return 8'h12;
    if (v[3:0] == 4'd0)  return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  function automatic logic [7:0] ms_inc(input logic [7:0] v);
    if (v == 8'h59)      return 8'h00;
    if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] ms_dec(input logic [7:0] v);
    if (v == 8'h00)      return 8'h59;
    if (v[3:0] == 4'd0)  return {v[7:4] - 4'd1, 4'd9};
    return {v[7:4], v[3:0] - 4'd1};
  endfunction

  // -------------------------------------------------------------------- FSM
  state_t        state_q, state_d;
  logic [7:0]    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          strobe_q, editing_q;
  logic [1:0]    field_q, field_d;
  logic          editing_d;
  logic          any_pulse, step_up, step_dn;

  assign any_pulse = p_mode | p_up | p_down;
  // Mode dominates; up and down together cancel.
  assign step_up   = p_up & ~p_down;
  assign step_dn   = p_down & ~p_up;

  // Next state, edit-register update and inactivity counter.
  always_comb begin
    state_d   = state_q;
    hh_d      = hh_q;
    mm_d      = mm_q;
    ss_d      = ss_q;
    to_cnt_d  = to_cnt_q;
    field_d   = 2'd0;
    editing_d = 1'b0;

    case (state_q)
      IDLE: begin
        to_cnt_d = '0;
        if (p_mode) begin
          hh_d    = hh_ok(clockBitsCurrent[23:16]) ? clockBitsCurrent[23:16] : 8'h12;
          mm_d    = ms_ok(clockBitsCurrent[15:8])  ? clockBitsCurrent[15:8]  : 8'h00;
          ss_d    = ms_ok(clockBitsCurrent[7:0])   ? clockBitsCurrent[7:0]   : 8'h00;
          state_d = EDIT_HH;
        end
      end
      EDIT_HH, EDIT_MM, EDIT_SS: begin
        to_cnt_d = any_pulse ? '0 : to_cnt_q + 1'b1;
        if (p_mode) begin
          case (state_q)
            EDIT_HH: state_d = EDIT_MM;
            EDIT_MM: state_d = EDIT_SS;
            default: state_d = COMMIT;
          endcase
        end else if (step_up || step_dn) begin
          case (state_q)
            EDIT_HH: hh_d = step_up ? hh_inc(hh_q) : hh_dec(hh_q);
            EDIT_MM: mm_d = step_up ? ms_inc(mm_q) : ms_dec(mm_q);
            default: ss_d = step_up ? ms_inc(ss_q) : ms_dec(ss_q);
          endcase
        end else if (!any_pulse && to_cnt_q == TO_LAST) begin
          // Abandon the edit silently; the edited word is left as it was.
          state_d  = IDLE;
          to_cnt_d = '0;
        end
      end
      COMMIT: begin
        to_cnt_d = '0;
        state_d  = IDLE;
      end
      default: begin
        to_cnt_d = '0;
        state_d  = IDLE;
      end
    endcase

    case (state_d)
      EDIT_HH: begin field_d = 2'd1; editing_d = 1'b1; end
      EDIT_MM: begin field_d = 2'd2; editing_d = 1'b1; end
      EDIT_SS: begin field_d = 2'd3; editing_d = 1'b1; end
      default: begin field_d = 2'd0; editing_d = 1'b0; end
    endcase
  end

  // State, edit register and registered status outputs, all updated on the same edge.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q   <= IDLE;
      hh_q      <= 8'h12;
      mm_q      <= 8'h00;
      ss_q      <= 8'h00;
      to_cnt_q  <= '0;
      strobe_q  <= 1'b0;
      editing_q <= 1'b0;
      field_q   <= 2'd0;
    end else begin
      state_q   <= state_d;
      hh_q      <= hh_d;
      mm_q      <= mm_d;
      ss_q      <= ss_d;
      to_cnt_q  <= to_cnt_d;
      strobe_q  <= (state_d == COMMIT);
      editing_q <= editing_d;
      field_q   <= field_d;
    end
  end

  assign clockBitsIn = {hh_q, mm_q, ss_q};
  assign loadStrobe  = strobe_q;
  assign editing     = editing_q;
  assign fieldSel    = field_q;

endmodule

// File: tb/tb_time_set_entry.sv
// Bench for time_set_entry: directed vector table, hand-timed corner sequences,
// and random button presses checked against a decimal-arithmetic model of the editor.
module tb_time_set_entry;

  localparam int DEB = 1;
`ifdef TIME_SET_DEBOUNCE_EN
  localparam int LAT = 2 + DEB;
`else
  localparam int LAT = 2;
`endif
  localparam int HOLD = LAT + 2;
  localparam int REL  = LAT + 2;
  localparam int TO   = 16;
  localparam int NV   = 23;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        btnMode = 1'b0, btnUp = 1'b0, btnDown = 1'b0;
  logic [23:0] cur_bits = 24'h0;
  logic [23:0] clockBitsIn;
  logic        loadStrobe;
  logic        editing;
  logic [1:0]  fieldSel;

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;
  logic [23:0] strobe_val = 24'h0;

  time_set_entry #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetN(resetN), .btnMode(btnMode), .btnUp(btnUp), .btnDown(btnDown),
    .clockBitsCurrent(cur_bits), .clockBitsIn(clockBitsIn), .loadStrobe(loadStrobe),
    .editing(editing), .fieldSel(fieldSel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Strobe monitor: counts strobe cycles and records the word presented with it.
  always @(negedge clk) begin
    if (loadStrobe === 1'b1) begin
      strobe_cnt++;
      strobe_val = clockBitsIn;
      check("strobe_editing_low", {31'd0, editing}, 32'd0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "time limit reached");
  end

  task automatic do_reset();
    @(negedge clk);
    resetN = 1'b0; btnMode = 1'b0; btnUp = 1'b0; btnDown = 1'b0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input logic m, input logic u, input logic d);
    @(negedge clk);
    btnMode = m; btnUp = u; btnDown = d;
    repeat (HOLD) @(negedge clk);
    btnMode = 1'b0; btnUp = 1'b0; btnDown = 1'b0;
    repeat (REL) @(negedge clk);
  endtask

  // ---------------------------------------------------------------- model
  int mh, mm, ms, mf;

  function automatic logic [23:0] to_bcd(input int h, input int m, input int s);
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  function automatic int dec2(input logic [7:0] b, input int lo, input int hi, input int dflt);
    int t, u;
    t = int'(b[7:4]);
    u = int'(b[3:0]);
    if (t > 9 || u > 9) return dflt;
    if (t * 10 + u < lo || t * 10 + u > hi) return dflt;
    return t * 10 + u;
  endfunction

  task automatic model_reset();
    mh = 12; mm = 0; ms = 0; mf = 0;
  endtask

  task automatic model_apply(input logic m, input logic u, input logic d,
                             input logic [23:0] c, output logic commit);
    commit = 1'b0;
    if (m) begin
      if (mf == 0) begin
        mh = dec2(c[23:16], 1, 12, 12);
        mm = dec2(c[15:8], 0, 59, 0);
        ms = dec2(c[7:0], 0, 59, 0);
        mf = 1;
      end else if (mf == 3) begin
        mf = 0;
        commit = 1'b1;
      end else begin
        mf = mf + 1;
      end
    end else if (mf != 0 && u != d) begin
      case (mf)
        1: mh = u ? (mh % 12) + 1 : ((mh + 10) % 12) + 1;
        2: mm = u ? (mm + 1) % 60 : (mm + 59) % 60;
        default: ms = u ? (ms + 1) % 60 : (ms + 59) % 60;
      endcase
    end
  endtask

  // --------------------------------------------------------------- vectors
  typedef struct {
    logic        m, u, d;
    logic [23:0] cur;
    logic [23:0] exp_bits;
    logic [1:0]  exp_fld;
    logic        exp_strobe;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    int s0;
    logic cm;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 24'h113045, 24'h113045, 2'd1, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 24'h235959, 24'h123045, 2'd1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 24'h235959, 24'h013045, 2'd1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 24'h235959, 24'h023045, 2'd1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 24'h235959, 24'h013045, 2'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 24'h235959, 24'h123045, 2'd1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 24'h235959, 24'h123045, 2'd1, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 24'h235959, 24'h123045, 2'd2, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 24'h235959, 24'h123045, 2'd3, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 24'h235959, 24'h123045, 2'd0, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 24'h105900, 24'h105900, 2'd1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 24'h000000, 24'h105900, 2'd2, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h100000, 2'd2, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 24'h000000, 24'h100000, 2'd3, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 24'h000000, 24'h100059, 2'd3, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h100000, 2'd3, 1'b0};
    vecs[16] = '{1'b0, 1'b0, 1'b1, 24'h000000, 24'h100059, 2'd3, 1'b0};
    vecs[17] = '{1'b1, 1'b0, 1'b0, 24'h000000, 24'h100059, 2'd0, 1'b1};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 24'h000000, 24'h100059, 2'd0, 1'b0};
    vecs[19] = '{1'b1, 1'b0, 1'b0, 24'h3A7F99, 24'h120000, 2'd1, 1'b0};
    vecs[20] = '{1'b1, 1'b0, 1'b1, 24'h000000, 24'h120000, 2'd2, 1'b0};
    vecs[21] = '{1'b1, 1'b0, 1'b0, 24'h000000, 24'h120000, 2'd3, 1'b0};
    vecs[22] = '{1'b1, 1'b0, 1'b0, 24'h000000, 24'h120000, 2'd0, 1'b1};

    // Reset values.
    do_reset();
    check("rst_bits",    {8'd0, clockBitsIn}, 32'h120000);
    check("rst_strobe",  {31'd0, loadStrobe}, 32'd0);
    check("rst_editing", {31'd0, editing}, 32'd0);
    check("rst_field",   {30'd0, fieldSel}, 32'd0);

    // Exact press-to-action latency on the first Mode press.
    cur_bits = 24'h113045;
    @(negedge clk);
    btnMode = 1'b1;
    repeat (LAT) @(negedge clk);
    check("lat_editing_early", {31'd0, editing}, 32'd0);
    @(negedge clk);
    check("lat_editing",  {31'd0, editing}, 32'd1);
    check("lat_field",    {30'd0, fieldSel}, 32'd1);
    check("lat_snapshot", {8'd0, clockBitsIn}, 32'h113045);
    repeat (HOLD) @(negedge clk);
    btnMode = 1'b0;
    repeat (REL) @(negedge clk);
    check("lat_held_once", {30'd0, fieldSel}, 32'd1);

    do_reset();
    check("rst2_bits", {8'd0, clockBitsIn}, 32'h120000);

    // Directed vector table.
    for (int i = 0; i < NV; i++) begin
      s0 = strobe_cnt;
      cur_bits = vecs[i].cur;
      press(vecs[i].m, vecs[i].u, vecs[i].d);
      check($sformatf("vec%0d_bits", i),   {8'd0, clockBitsIn}, {8'd0, vecs[i].exp_bits});
      check($sformatf("vec%0d_field", i),  {30'd0, fieldSel}, {30'd0, vecs[i].exp_fld});
      check($sformatf("vec%0d_edit", i),   {31'd0, editing}, {31'd0, vecs[i].exp_fld != 2'd0});
      check($sformatf("vec%0d_strobes", i), strobe_cnt - s0, {31'd0, vecs[i].exp_strobe});
      if (vecs[i].exp_strobe)
        check($sformatf("vec%0d_strobe_val", i), {8'd0, strobe_val}, {8'd0, vecs[i].exp_bits});
    end

    // Inactivity timeout in EDIT_MM.
    s0 = strobe_cnt;
    cur_bits = 24'h073015;
    press(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    btnMode = 1'b1;
    repeat (LAT + 1) @(negedge clk);
    check("to_enter_mm", {30'd0, fieldSel}, 32'd2);
    btnMode = 1'b0;
    repeat (TO - 1) @(negedge clk);
    check("to_before_field", {30'd0, fieldSel}, 32'd2);
    check("to_before_edit",  {31'd0, editing}, 32'd1);
    @(negedge clk);
    check("to_field",   {30'd0, fieldSel}, 32'd0);
    check("to_edit",    {31'd0, editing}, 32'd0);
    check("to_bits",    {8'd0, clockBitsIn}, 32'h073015);
    check("to_strobes", strobe_cnt - s0, 32'd0);

    // Reset asserted at the edge that would enter COMMIT.
    cur_bits = 24'h045612;
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("rc_in_ss", {30'd0, fieldSel}, 32'd3);
    s0 = strobe_cnt;
    @(negedge clk);
    btnMode = 1'b1;
    repeat (LAT) @(negedge clk);
    resetN = 1'b0;
    btnMode = 1'b0;
    @(negedge clk);
    check("rc_strobe", {31'd0, loadStrobe}, 32'd0);
    check("rc_bits",   {8'd0, clockBitsIn}, 32'h120000);
    check("rc_edit",   {31'd0, editing}, 32'd0);
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    repeat (6) @(negedge clk);
    check("rc_strobes", strobe_cnt - s0, 32'd0);
    check("rc_field",   {30'd0, fieldSel}, 32'd0);

    // Random presses against the model.
    do_reset();
    model_reset();
    for (int n = 0; n < 80; n++) begin
      int r;
      logic m, u, d;
      r = $urandom_range(0, 9);
      m = (r <= 1) || (r == 9);
      u = (r >= 2 && r <= 4) || (r == 8) || (r == 9 && $urandom_range(0, 1) == 1);
      d = (r >= 5 && r <= 8) || (r == 9 && !u);
      if ($urandom_range(0, 1) == 1)
        cur_bits = to_bcd($urandom_range(1, 12), $urandom_range(0, 59), $urandom_range(0, 59));
      else
        cur_bits = 24'($urandom);
      s0 = strobe_cnt;
      model_apply(m, u, d, cur_bits, cm);
      press(m, u, d);
      check($sformatf("rnd%0d_bits", n),    {8'd0, clockBitsIn}, {8'd0, to_bcd(mh, mm, ms)});
      check($sformatf("rnd%0d_field", n),   {30'd0, fieldSel}, 32'(mf));
      check($sformatf("rnd%0d_edit", n),    {31'd0, editing}, {31'd0, mf != 0});
      check($sformatf("rnd%0d_strobes", n), strobe_cnt - s0, {31'd0, cm});
      if (cm)
        check($sformatf("rnd%0d_strobe_val", n), {8'd0, strobe_val}, {8'd0, to_bcd(mh, mm, ms)});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/time_set_entry.md
# time_set_entry

Button-driven time-setting editor that produces the 24-bit BCD preset word consumed by the `Clock` digit chain (hours tens/units, minutes tens/units, seconds tens/units, 12-hour range 01:00:00–12:59:59). It sits between the board push-buttons and the clock core. It snapshots the running time, lets the user step each field up or down with wrap-around, and commits the result with a one-cycle load strobe. It is the writer side of the `clockBitsIn` interface that the clock core reads.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1000000: stable cycles required before a button level is accepted (only with `TIME_SET_DEBOUNCE_EN`).
- `TIMEOUT_CYCLES`, default 500000000: idle cycles in any edit state before the edit is abandoned.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `resetN`  in  1  synchronous, active-low reset.
- `btnMode`  in  1  raw mode button, active-high, asynchronous to `clk`.
- `btnUp`  in  1  raw increment button, active-high, asynchronous.
- `btnDown`  in  1  raw decrement button, active-high, asynchronous.
- `clockBitsCurrent`  in  24  running BCD time from the clock core, same field layout as the output.
- `clockBitsIn`  out  24  edited BCD time: [23:20] HH tens, [19:16] HH units, [15:12] MM tens, [11:8] MM units, [7:4] SS tens, [3:0] SS units.
- `loadStrobe`  out  1  one-cycle pulse; `clockBitsIn` is valid for loading in that cycle.
- `editing`  out  1  high in any EDIT state.
- `fieldSel`  out  2  field being edited: 0 = none, 1 = HH, 2 = MM, 3 = SS.

## Operation
- Each button passes through a 2-flop synchronizer, optional debounce, then a rising-edge detector. The detector emits a one-cycle pulse: `pMode`, `pUp` or `pDown`.
- States: IDLE, EDIT_HH, EDIT_MM, EDIT_SS, COMMIT.
- IDLE + `pMode`:
  - Capture `clockBitsCurrent` into the edit register, then go to EDIT_HH.
  - Any field that is non-BCD or out of range is replaced on capture: HH → 12, MM → 00, SS → 00.
- EDIT_x + `pUp`: field +1 in BCD. Wraps are HH 12 → 01, MM 59 → 00, SS 59 → 00.
- EDIT_x + `pDown`: field −1 in BCD. Wraps are HH 01 → 12, MM 00 → 59, SS 00 → 59.
- Fields never carry into or borrow from each other.
- `pMode` advances the state: EDIT_HH → EDIT_MM → EDIT_SS → COMMIT.
- COMMIT lasts exactly one cycle, asserts `loadStrobe`, then returns to IDLE. Commit is unconditional and ignores buttons.
- Same-cycle event rules:
  - `pMode` together with `pUp` or `pDown`: mode wins and the up/down pulse is dropped.
  - `pUp` and `pDown` together, without mode: both are ignored.
- Inactivity timeout:
  - The counter clears on any pulse and on entry to EDIT_HH.
  - When it reaches `TIMEOUT_CYCLES` in an EDIT state, go to IDLE with no strobe. `clockBitsIn` keeps its last edited value.
- In IDLE, up/down pulses are ignored.
- Holding a button produces exactly one pulse. A new pulse requires release and re-press.

## Timing
- Reset (`resetN` low at a rising edge):
  - State = IDLE, `clockBitsIn` = 24'h120000, `loadStrobe` = 0, `editing` = 0, `fieldSel` = 0.
  - Synchronizers, edge registers and counters clear to 0.
- A reset in any state, including COMMIT, takes effect at that edge and suppresses any pending strobe.
- Without debounce: a button first sampled high at edge k acts at edge k+2. The state/field update is visible after edge k+2.
- With debounce: action at edge k+2+`DEBOUNCE_CYCLES`.
- Outputs are registered and have no combinational path from the inputs.
- `editing` and `fieldSel` change at the same edge as the state.
- `loadStrobe` is high for the single cycle after the edge that entered COMMIT. `clockBitsIn` is stable for that whole cycle.
- The snapshot of `clockBitsCurrent` is taken at the same edge that leaves IDLE.

## Configuration
- Macro: `TIME_SET_DEBOUNCE_EN`.
- Defined:
  - Each synchronized button feeds a counter that must see a stable level for `DEBOUNCE_CYCLES` consecutive cycles before the accepted level changes.
  - Any glitch restarts the count.
- Undefined: the accepted level equals the second synchronizer stage. The counters and the parameter are unused.

## Test plan
- Reset, then Mode with `clockBitsCurrent` = 24'h113045 → `editing` = 1, `fieldSel` = 1, `clockBitsIn` = 24'h113045 two edges after the press is sampled.
- In EDIT_HH from 11: Up, Up, Up → hours 12, 01, 02. Then Down ×2 → 01, 12.
- EDIT_MM at 59: Up → 00 with hours unchanged. Then EDIT_SS at 00: Down → 59.
- Full sequence Mode ×4 → exactly one `loadStrobe` pulse, `clockBitsIn` = edited value, `editing` drops the same edge.
- Up and Down pressed in the same cycle → no change. Mode plus Up in the same cycle → field advances and the value is unchanged.
- `TIMEOUT_CYCLES` = 16 with no presses in EDIT_MM → IDLE after 16 cycles with no strobe. Separately, `resetN` low during COMMIT → no strobe and `clockBitsIn` = 24'h120000.
